uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  Parametrised UART transmitter. It serialises DATA_WIDTH-bit words into frames:
//  start bit, data LSB-first, optional parity, then STOP_BITS stop bits.
//  Words arrive on a valid/ready handshake. A one-entry holding register allows
//  back-to-back frames with no idle gap. Sits between the board-level command
//  logic and the Zybo Z7-20 UART TX pin.
// PARAMETERS
//  DATA_WIDTH    8     data bits per frame; legal 5..9
//  CLKS_PER_BIT  1085  sysclk cycles per bit (125 MHz / 115200); legal >= 2
//  STOP_BITS     1     stop bits per frame; legal 1 or 2
//  PARITY_ODD    0     0 = even parity, 1 = odd parity (used only with UART_TX_PARITY_EN)
// PORTS
//  sysclk       in   1           system clock; all logic on posedge
//  rst_n        in   1           asynchronous reset, active-low
//  i_tx_en      in   1           transmitter enable; low aborts and flushes
//  i_tx_valid   in   1           i_tx_byte holds a word to send
//  i_tx_byte    in   DATA_WIDTH  word to transmit
//  o_tx_ready   out  1           holding register empty; word accepted when valid&&ready
//  o_tx_serial  out  1           serial line; idles high
//  o_tx_busy    out  1           frame in progress (state != IDLE)
//  o_tx_d       out  1           one-cycle pulse: a frame's last stop bit has completed
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, o_tx_serial=1, o_tx_ready=0, o_tx_busy=0,
//   o_tx_d=0, holding empty, counters 0. First cycle after release: o_tx_ready=i_tx_en.
//  o_tx_ready = i_tx_en && holding empty. It is registered and does not depend on i_tx_valid.
//  Accept: on the edge with i_tx_valid&&o_tx_ready, the word goes to the holding register.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE/START.
//  IDLE: holding full -> load shifter, free holding, enter START. The start bit (0)
//   appears on o_tx_serial on the next edge. Accept-to-start-bit latency: 2 cycles.
//  Each bit is driven for exactly CLKS_PER_BIT cycles.
//   Baud counter width = $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1, then wraps.
//  DATA: bit index counts 0..DATA_WIDTH-1. Index width = $clog2(DATA_WIDTH+1); no overflow.
//  STOP: line held 1 for STOP_BITS*CLKS_PER_BIT cycles.
//  End of STOP: o_tx_d=1 for exactly one cycle. If holding is full at that edge,
//   go straight to START (no idle bit) and free holding; otherwise go to IDLE.
//  Simultaneous accept and holding->shifter transfer in the same cycle: the new word
//   is held and o_tx_ready stays 0. No word is lost or duplicated.
//  i_tx_valid while o_tx_ready=0: ignored; the word is not captured.
//  i_tx_en deassert mid-frame: next edge gives IDLE, line=1, holding flushed,
//   o_tx_d=0, o_tx_ready=0. The partial frame is discarded with no done pulse.
//  rst_n low mid-frame: line forced high immediately (async).
//  Frame length = CLKS_PER_BIT*(1+DATA_WIDTH+P+STOP_BITS), where P=1 with parity, else 0.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: the PARITY state runs after DATA and drives one bit.
//   Bit value = ^data ^ PARITY_ODD (even parity: XOR of data bits).
//  UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; DATA goes straight
//   to STOP. PARITY_ODD is ignored.
// TESTING (bench: CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 unless stated)
//  Reset release, en=1, send 8'hA5 -> line 0,1,0,1,0,0,1,0,1,1 (4 clks each);
//   o_tx_d pulses once, 40 cycles after start bit begins.
//  Two words 8'h00, 8'hFF presented back-to-back -> second start bit follows first
//   stop bit with zero idle cycles; two o_tx_d pulses 40 cycles apart.
//  i_tx_en dropped during data bit 3 of 8'h3C -> line high next cycle, no o_tx_d,
//   o_tx_ready=0 until en returns.
//  rst_n pulsed low mid-frame -> o_tx_serial=1 asynchronously; all outputs at reset values.
//  STOP_BITS=2, send 8'h81 -> stop high for 8 cycles; o_tx_d at cycle 44.
//  UART_TX_PARITY_EN, PARITY_ODD=0, send 8'h07 -> parity bit 1;
//   with PARITY_ODD=1 -> parity bit 0; frame 44 cycles.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Serialises DATA_WIDTH-bit words as
// start bit, data LSB-first, optional parity, then STOP_BITS stop bits.
// A one-entry holding register allows back-to-back frames with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD=1).
//
// Ports:
//   sysclk      system clock, all logic on posedge
//   rst_n       asynchronous reset, active-low
//   i_tx_en     transmitter enable; low aborts the frame and flushes holding
//   i_tx_valid  i_tx_byte holds a word to send
//   i_tx_byte   word to transmit
//   o_tx_ready  holding register empty; word accepted when valid && ready
//   o_tx_serial serial line, idles high
//   o_tx_busy   frame in progress (state != IDLE)
//   o_tx_d      one-cycle pulse when a frame's last stop bit has completed
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1085,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  i_tx_en,
  input  logic                  i_tx_valid,
  input  logic [DATA_WIDTH-1:0] i_tx_byte,
  output logic                  o_tx_ready,
  output logic                  o_tx_serial,
  output logic                  o_tx_busy,
  output logic                  o_tx_d
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CLKS_PER_BIT < 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_tx_frame: illegal parameter value");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [BW-1:0]         baud_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shifter;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  stop_done;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  logic accept;
  logic bit_end;
  logic stop_exit;
  logic take_hold;
  logic hold_full_nxt;

  always_comb begin
    accept    = i_tx_valid && o_tx_ready;
    bit_end   = (baud_cnt == BAUD_LAST);
    stop_exit = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
    take_hold = hold_full && ((state == IDLE) || stop_exit);
    // A word accepted on the transfer edge stays held (accept wins).
    hold_full_nxt = hold_full;
    if (accept) begin
      hold_full_nxt = 1'b1;
    end else if (take_hold) begin
      hold_full_nxt = 1'b0;
    end
  end

  assign o_tx_busy = (state != IDLE);

  // o_tx_serial is registered from the current state, so the line trails the
  // state register by one cycle; o_tx_d is delayed by stop_done to match.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shifter     <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      stop_done   <= 1'b0;
      o_tx_ready  <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_d      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else if (!i_tx_en) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      hold_full   <= 1'b0;
      stop_done   <= 1'b0;
      o_tx_ready  <= 1'b0;
      o_tx_serial <= 1'b1;
      o_tx_d      <= 1'b0;
    end else begin
      hold_full  <= hold_full_nxt;
      o_tx_ready <= !hold_full_nxt;
      o_tx_d     <= stop_done;
      stop_done  <= 1'b0;
      if (accept) begin
        hold_data <= i_tx_byte;
      end

      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          o_tx_serial <= 1'b1;
          baud_cnt    <= '0;
          if (hold_full) begin
            state <= START;
          end
        end
        START: begin
          o_tx_serial <= 1'b0;
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          o_tx_serial <= shifter[0];
          if (bit_end) begin
            shifter <= shifter >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          o_tx_serial <= parity_bit;
          if (bit_end) begin
            state   <= STOP;
            bit_idx <= '0;
          end
        end
`endif
        STOP: begin
          o_tx_serial <= 1'b1;
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx   <= '0;
              stop_done <= 1'b1;
              state     <= hold_full ? START : IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (take_hold) begin
        shifter    <= hold_data;
`ifdef UART_TX_PARITY_EN
        parity_bit <= (^hold_data) ^ 1'(PARITY_ODD);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int NDUT = 4;
`else
  localparam int NDUT = 2;
`endif

  logic       sysclk;
  logic       rst_n;
  logic       en;
  logic       valid_w [NDUT];
  logic [7:0] byte_w  [NDUT];
  logic       ready_w [NDUT];
  logic       ser_w   [NDUT];
  logic       busy_w  [NDUT];
  logic       d_w     [NDUT];

  int errors = 0;
  int checks = 0;

  // 0: default frame; 1: two stop bits; 2/3: even/odd parity
  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .sysclk(sysclk), .rst_n(rst_n), .i_tx_en(en), .i_tx_valid(valid_w[0]), .i_tx_byte(byte_w[0]),
    .o_tx_ready(ready_w[0]), .o_tx_serial(ser_w[0]), .o_tx_busy(busy_w[0]), .o_tx_d(d_w[0]));

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .sysclk(sysclk), .rst_n(rst_n), .i_tx_en(en), .i_tx_valid(valid_w[1]), .i_tx_byte(byte_w[1]),
    .o_tx_ready(ready_w[1]), .o_tx_serial(ser_w[1]), .o_tx_busy(busy_w[1]), .o_tx_d(d_w[1]));

`ifdef UART_TX_PARITY_EN
  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut2 (
    .sysclk(sysclk), .rst_n(rst_n), .i_tx_en(en), .i_tx_valid(valid_w[2]), .i_tx_byte(byte_w[2]),
    .o_tx_ready(ready_w[2]), .o_tx_serial(ser_w[2]), .o_tx_busy(busy_w[2]), .o_tx_d(d_w[2]));

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(1)) dut3 (
    .sysclk(sysclk), .rst_n(rst_n), .i_tx_en(en), .i_tx_valid(valid_w[3]), .i_tx_byte(byte_w[3]),
    .o_tx_ready(ready_w[3]), .o_tx_serial(ser_w[3]), .o_tx_busy(busy_w[3]), .o_tx_d(d_w[3]));
`endif

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Present a word and hold valid until the edge that accepts it.
  task automatic push(input int sel, input logic [7:0] b, output bit to);
    int w;
    to = 1'b0;
    w = 0;
    valid_w[sel] = 1'b1;
    byte_w[sel]  = b;
    while (ready_w[sel] !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) to = 1'b1;
    tick();
    valid_w[sel] = 1'b0;
  endtask

  // Wait for the start bit, then record n line samples; sample 0 is the first
  // cycle of the start bit. o_tx_d pulses are logged over n+4 samples.
  task automatic capture(input int sel, input int n, output logic [95:0] line,
                         output int d0, output int d1, output int d_cnt, output bit to);
    int w;
    to = 1'b0;
    line = '0;
    d0 = -1;
    d1 = -1;
    d_cnt = 0;
    w = 0;
    while (ser_w[sel] !== 1'b0 && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) to = 1'b1;
    for (int k = 0; k < n + 4; k++) begin
      if (k < n) line[k] = ser_w[sel];
      if (d_w[sel] === 1'b1) begin
        if (d_cnt == 0) d0 = k;
        else if (d_cnt == 1) d1 = k;
        d_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      valid_w[i] = 1'b0;
      byte_w[i]  = '0;
    end
    repeat (3) tick();
    checks++; if (ser_w[0] !== 1'b1) begin errors++; $display("FAIL rst_serial: got %b expected 1", ser_w[0]); end
    checks++; if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_w[0]); end
    checks++; if (d_w[0] !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", d_w[0]); end
    rst_n = 1'b1;
    tick();
    checks++; if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b expected 1", ready_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL rel_busy: got %b expected 0", busy_w[0]); end
  endtask

  task automatic test_single_a5();
    logic [95:0] line;
    logic [9:0]  exp;
    int d0, d1, dc;
    bit to;
    push(0, 8'hA5, to);
    checks++; if (to) begin errors++; $display("FAIL a5_push: got timeout expected accept"); end
    checks++; if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL a5_ready_after_accept: got %b expected 0", ready_w[0]); end
    capture(0, 40, line, d0, d1, dc, to);
    checks++; if (to) begin errors++; $display("FAIL a5_start: got timeout expected start bit"); end
    exp = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (line[4*b +: 4] !== {4{exp[b]}}) begin
        errors++;
        $display("FAIL a5_bit%0d: got %b expected %b", b, line[4*b +: 4], {4{exp[b]}});
      end
    end
    checks++; if (dc !== 1) begin errors++; $display("FAIL a5_done_count: got %0d expected 1", dc); end
    checks++; if (d0 !== 40) begin errors++; $display("FAIL a5_done_pos: got %0d expected 40", d0); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL a5_busy_end: got %b expected 0", busy_w[0]); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] line;
    logic [21:0] exp;
    int d0, d1, dc;
    bit to_a, to_b, to_c;
    fork
      begin
        push(0, 8'h00, to_a);
        push(0, 8'hFF, to_b);
        // holding is full now: these attempts must be ignored
        for (int i = 0; i < 10; i++) begin
          valid_w[0] = 1'b1;
          byte_w[0]  = 8'hEE;
          tick();
          checks++;
          if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_full%0d: got %b expected 0", i, ready_w[0]); end
        end
        valid_w[0] = 1'b0;
      end
      capture(0, 88, line, d0, d1, dc, to_c);
    join
    checks++; if (to_a || to_b || to_c) begin errors++; $display("FAIL b2b_timeout: got %b%b%b expected 000", to_a, to_b, to_c); end
    exp = {2'b11, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    for (int b = 0; b < 22; b++) begin
      checks++;
      if (line[4*b +: 4] !== {4{exp[b]}}) begin
        errors++;
        $display("FAIL b2b_bit%0d: got %b expected %b", b, line[4*b +: 4], {4{exp[b]}});
      end
    end
    checks++; if (dc !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dc); end
    checks++; if (d0 !== 40) begin errors++; $display("FAIL b2b_done0_pos: got %0d expected 40", d0); end
    checks++; if (d1 !== 80) begin errors++; $display("FAIL b2b_done1_pos: got %0d expected 80", d1); end
  endtask

  task automatic test_en_drop();
    int w, d_seen, r_seen;
    bit to;
    push(0, 8'h3C, to);
    checks++; if (to) begin errors++; $display("FAIL en_push: got timeout expected accept"); end
    w = 0;
    while (ser_w[0] !== 1'b0 && w < 40) begin tick(); w++; end
    checks++; if (w >= 40) begin errors++; $display("FAIL en_start: got timeout expected start bit"); end
    for (int k = 0; k < 17; k++) begin
      if (k == 4) begin
        checks++; if (ser_w[0] !== 1'b0) begin errors++; $display("FAIL en_data_bit0: got %b expected 0", ser_w[0]); end
      end
      tick();
    end
    checks++; if (ser_w[0] !== 1'b1) begin errors++; $display("FAIL en_data_bit3: got %b expected 1", ser_w[0]); end
    en = 1'b0;
    tick();
    checks++; if (ser_w[0] !== 1'b1) begin errors++; $display("FAIL en_line: got %b expected 1", ser_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL en_busy: got %b expected 0", busy_w[0]); end
    checks++; if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL en_ready: got %b expected 0", ready_w[0]); end
    d_seen = 0;
    r_seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (d_w[0] !== 1'b0) d_seen++;
      if (ready_w[0] !== 1'b0) r_seen++;
      tick();
    end
    checks++; if (d_seen !== 0) begin errors++; $display("FAIL en_no_done: got %0d pulses expected 0", d_seen); end
    checks++; if (r_seen !== 0) begin errors++; $display("FAIL en_ready_low: got %0d ready cycles expected 0", r_seen); end
    en = 1'b1;
    tick();
    checks++; if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL en_ready_back: got %b expected 1", ready_w[0]); end
  endtask

  task automatic test_stop2();
    logic [95:0] line;
    logic [11:0] exp;
    int d0, d1, dc;
    bit to_a, to_b;
    push(1, 8'h81, to_a);
    capture(1, 48, line, d0, d1, dc, to_b);
    checks++; if (to_a || to_b) begin errors++; $display("FAIL stop2_timeout: got %b%b expected 00", to_a, to_b); end
    exp = {1'b1, 2'b11, 8'h81, 1'b0};
    for (int b = 0; b < 12; b++) begin
      checks++;
      if (line[4*b +: 4] !== {4{exp[b]}}) begin
        errors++;
        $display("FAIL stop2_bit%0d: got %b expected %b", b, line[4*b +: 4], {4{exp[b]}});
      end
    end
    checks++; if (dc !== 1) begin errors++; $display("FAIL stop2_done_count: got %0d expected 1", dc); end
    checks++; if (d0 !== 44) begin errors++; $display("FAIL stop2_done_pos: got %0d expected 44", d0); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [95:0] line;
    logic [11:0] exp;
    logic        pbit;
    int d0, d1, dc;
    bit to_a, to_b;
    for (int s = 2; s < 4; s++) begin
      pbit = (s == 2) ? 1'b1 : 1'b0;
      push(s, 8'h07, to_a);
      capture(s, 48, line, d0, d1, dc, to_b);
      checks++; if (to_a || to_b) begin errors++; $display("FAIL par%0d_timeout: got %b%b expected 00", s, to_a, to_b); end
      exp = {1'b1, 1'b1, pbit, 8'h07, 1'b0};
      for (int b = 0; b < 12; b++) begin
        checks++;
        if (line[4*b +: 4] !== {4{exp[b]}}) begin
          errors++;
          $display("FAIL par%0d_bit%0d: got %b expected %b", s, b, line[4*b +: 4], {4{exp[b]}});
        end
      end
      checks++; if (d0 !== 44) begin errors++; $display("FAIL par%0d_done_pos: got %0d expected 44", s, d0); end
    end
  endtask
`endif

  task automatic test_reset_midframe();
    int w;
    bit to;
    push(0, 8'h00, to);
    checks++; if (to) begin errors++; $display("FAIL mrst_push: got timeout expected accept"); end
    w = 0;
    while (ser_w[0] !== 1'b0 && w < 40) begin tick(); w++; end
    repeat (6) tick();
    checks++; if (ser_w[0] !== 1'b0) begin errors++; $display("FAIL mrst_running: got %b expected 0", ser_w[0]); end
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL mrst_busy_before: got %b expected 1", busy_w[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ser_w[0] !== 1'b1) begin errors++; $display("FAIL mrst_serial: got %b expected 1", ser_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b expected 0", busy_w[0]); end
    checks++; if (ready_w[0] !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %b expected 0", ready_w[0]); end
    checks++; if (d_w[0] !== 1'b0) begin errors++; $display("FAIL mrst_done: got %b expected 0", d_w[0]); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL mrst_ready_rel: got %b expected 1", ready_w[0]); end
    repeat (10) tick();
    checks++; if (ser_w[0] !== 1'b1) begin errors++; $display("FAIL mrst_idle_line: got %b expected 1", ser_w[0]); end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_en_drop();
    test_stop2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
